jk_bank: RTL

JK_BANK -- requirements
Module: jk_bank

---
 rtl/jk_bank_pkg.sv | 17 +
 rtl/jk_cell.sv | 35 +++
 rtl/jk_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/jk_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_pkg
// Brief    : Mode encoding shared by the JK register bank and its testbench.
// Revision : 1.0 - initial release
// ============================================================================
package jk_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_SHIFT = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

endpackage : jk_bank_pkg
`default_nettype wire

// File: rtl/jk_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_cell
// Brief    : Single JK bit-cell with synchronous reset to a per-cell value.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic init_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= init_val;
        end else if (en) begin
            case ({j, k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule : jk_cell
`default_nettype wire

// File: rtl/jk_bank.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank
// Brief    : Bank of JK cells operated as JK register, counter or shifter.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank
    import jk_bank_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic             tc
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_shift_d;
    logic [WIDTH:0]   w_carry;
    logic             w_cell_en;
    logic             r_tc;

    // Ripple carry: bit i toggles in COUNT mode only when all lower bits are 1.
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
        assign w_carry[gi+1] = w_carry[gi] & w_q[gi];
        if (gi == 0) begin : g_shift_lsb
            assign w_shift_d[gi] = sin;
        end else begin : g_shift_upper
            assign w_shift_d[gi] = w_q[gi-1];
        end
    end

    always_comb begin
        w_j       = j;
        w_k       = k;
        w_cell_en = en;
        case (mode_e'(mode))
            MODE_COUNT: begin
                w_j = w_carry[WIDTH-1:0];
                w_k = w_carry[WIDTH-1:0];
            end
            MODE_SHIFT: begin
                w_j = w_shift_d;
                w_k = ~w_shift_d;
            end
            MODE_HOLD: w_cell_en = 1'b0;
            default:   ;
        endcase
    end

    for (genvar gc = 0; gc < WIDTH; gc++) begin : g_cell
        jk_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .init_val (INIT[gc]),
            .en       (w_cell_en),
            .j        (w_j[gc]),
            .k        (w_k[gc]),
            .q        (w_q[gc])
        );
    end

    // Wrap pulse registered alongside the all-ones -> zero transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= en && (mode_e'(mode) == MODE_COUNT) && w_carry[WIDTH];
        end
    end

    assign q    = w_q;
    assign qb   = ~w_q;
    assign sout = w_q[WIDTH-1];
    assign tc   = r_tc;

endmodule : jk_bank
`default_nettype wire
